// File: rtl/por_pkg.sv
// Shared definitions for the power-up qualifier and the POR debug decode.
package por_pkg;

  // Qualifier FSM states; the encoding is exported on filt_state for debug.
  typedef enum logic [1:0] {
    LOW     = 2'b00,
    QUAL_UP = 2'b01,
    HIGH    = 2'b10,
    QUAL_DN = 2'b11
  } pwup_state_e;

  // Saturation value of the rejected-glitch counter.
  localparam logic [7:0] GLITCH_MAX = 8'hFF;

  // The qualified level is high while the supply is good or still being re-qualified low.
  function automatic logic state_is_high(input pwup_state_e st);
    return (st == HIGH) || (st == QUAL_DN);
  endfunction

endpackage

// File: rtl/por_sync.sv
// N-stage synchroniser for a single asynchronous bit into the local clock domain.
module por_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{1'b0}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/por_pwup_qual.sv
// Power-up qualifier: synchronises the supply-trip comparator and applies
// slow-rise / fast-fall debounce, with a sticky brown-out flag and a
// saturating rejected-glitch counter for debug.
module por_pwup_qual
  import por_pkg::*;
#(
  parameter int UP_CNT      = 64,
  parameter int DN_CNT      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       osc_ck,
  input  logic       rst,
  input  logic       cmp_raw,
  input  logic       force_pwup,
  input  logic       clr_bod,
  output logic       pwup_filt,
  output logic       bod_flag,
  output logic [7:0] glitch_cnt,
  output logic [1:0] filt_state
);

  localparam logic [CNT_W-1:0] UP_LAST = CNT_W'(UP_CNT - 1);
  localparam logic [CNT_W-1:0] DN_LAST = CNT_W'(DN_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              s_cmp_s;
  pwup_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pwup_q, pwup_d;
  logic              bod_q, bod_d;
  logic [7:0]        glitch_q, glitch_d;
  logic              glitch_ev_s;
  logic              bod_set_s;

  por_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (osc_ck),
    .rst (rst),
    .d_i (cmp_raw),
    .q_o (s_cmp_s)
  );

  // Next-state and counter logic; force overrides qualification without side effects.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    glitch_ev_s = 1'b0;
    bod_set_s   = 1'b0;
    if (force_pwup) begin
      state_d = HIGH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOW: begin
          if (s_cmp_s) begin
            state_d = QUAL_UP;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = LOW;
            cnt_d   = '0;
          end
        end
        QUAL_UP: begin
          if (s_cmp_s) begin
            if (cnt_q == UP_LAST) begin
              state_d = HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d     = LOW;
            cnt_d       = '0;
            glitch_ev_s = 1'b1;
          end
        end
        HIGH: begin
          if (!s_cmp_s) begin
            state_d = QUAL_DN;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = HIGH;
            cnt_d   = '0;
          end
        end
        QUAL_DN: begin
          if (!s_cmp_s) begin
            if (cnt_q == DN_LAST) begin
              state_d   = LOW;
              cnt_d     = '0;
              bod_set_s = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d     = HIGH;
            cnt_d       = '0;
            glitch_ev_s = 1'b1;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Flag, saturating counter and output-level next values.
  always_comb begin
    pwup_d = state_is_high(state_d);
    if (bod_set_s) begin
      bod_d = 1'b1;
    end else if (clr_bod) begin
      bod_d = 1'b0;
    end else begin
      bod_d = bod_q;
    end
    if (glitch_ev_s && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 8'd1;
    end else begin
      glitch_d = glitch_q;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge osc_ck) begin
    if (rst) begin
      state_q  <= LOW;
      cnt_q    <= '0;
      pwup_q   <= 1'b0;
      bod_q    <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwup_q   <= pwup_d;
      bod_q    <= bod_d;
      glitch_q <= glitch_d;
    end
  end

  assign pwup_filt  = pwup_q;
  assign bod_flag   = bod_q;
  assign glitch_cnt = glitch_q;
  assign filt_state = state_q;

endmodule

// File: doc/por_pwup_qual.md
# por_pwup_qual

Digital power-up qualifier that sits directly upstream of the POR one-shot logic. It synchronises the raw supply-trip comparator output into the `osc_ck` domain and applies asymmetric debounce: slow qualification on rise, fast on fall. It produces the clean `pwup_filt` level that gates the POR oscillator enable and the startup/POR counters. It also keeps a sticky brown-out flag and a saturating count of rejected glitches for debug readout.

## Interface
- `UP_CNT`, default 64: consecutive synchronised high samples required to assert `pwup_filt`; legal range 2..2^CNT_W-1.
- `DN_CNT`, default 4: consecutive synchronised low samples required to deassert `pwup_filt`; legal range 2..2^CNT_W-1.
- `CNT_W`, default 8: width of the qualification counter.
- `SYNC_STAGES`, default 2: synchroniser depth on `cmp_raw`; minimum 2.
- `osc_ck` input 1: RC oscillator clock, the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `cmp_raw` input 1: asynchronous trip-comparator output; 1 means the supply is above the trip level.
- `force_pwup` input 1: debug override that forces the qualified-high state.
- `clr_bod` input 1: clears `bod_flag`, level-sensitive.
- `pwup_filt` output 1: qualified power-good level, registered.
- `bod_flag` output 1: sticky brown-out indicator.
- `glitch_cnt` output 8: saturating count of rejected pulses.
- `filt_state` output 2: current FSM state, for debug.

## Operation
- **Synchroniser.** `cmp_raw` passes through SYNC_STAGES flops to give `s_cmp`. The FSM uses only `s_cmp`.
- **FSM states:** LOW=00, QUAL_UP=01, HIGH=10, QUAL_DN=11.
- **`pwup_filt`:** registered; equals 1 exactly when the state is HIGH or QUAL_DN.
- **LOW:**
  - `s_cmp`=1 → QUAL_UP with cnt=1.
  - otherwise stay in LOW with cnt=0.
- **QUAL_UP:**
  - `s_cmp`=1 and cnt==UP_CNT-1 → HIGH, cnt=0.
  - `s_cmp`=1 otherwise → cnt+1.
  - `s_cmp`=0 → LOW, cnt=0, `glitch_cnt`+1.
- **HIGH:**
  - `s_cmp`=0 → QUAL_DN with cnt=1.
  - otherwise stay in HIGH.
- **QUAL_DN:**
  - `s_cmp`=0 and cnt==DN_CNT-1 → LOW, cnt=0, `bod_flag` set.
  - `s_cmp`=0 otherwise → cnt+1.
  - `s_cmp`=1 → HIGH, cnt=0, `glitch_cnt`+1.
- **`force_pwup`=1:** next state is HIGH from any state, cnt=0. No glitch count and no `bod_flag` change in that cycle. When it is released, normal qualification resumes from HIGH.
- **`glitch_cnt`:** saturates at 255 and never wraps. It is cleared only by `rst`.
- **`bod_flag`:**
  - Set only by the QUAL_DN→LOW transition.
  - Cleared by `clr_bod`=1.
  - If set and clear occur in the same cycle, set wins.
- **Counter width:** cnt is CNT_W bits and never exceeds max(UP_CNT, DN_CNT)-1, so no wrap is possible.

## Timing
- **Reset:** `rst` sampled high at an edge gives, after that edge:
  - state LOW, cnt=0, all synchroniser flops 0;
  - `pwup_filt`=0, `bod_flag`=0, `glitch_cnt`=0, `filt_state`=00.
- **Reset mid-operation:** `pwup_filt` drops after the same edge. Reset never sets `bod_flag`. `rst` has priority over `force_pwup`.
- **Rise latency:** let edge 0 be the edge that first captures `cmp_raw`=1, with the input held. `pwup_filt`=1 after edge SYNC_STAGES+UP_CNT-1, which is edge 65 at defaults.
- **Fall latency:** let edge 0 be the first edge capturing `cmp_raw`=0, with the input held. `pwup_filt`=0 and `bod_flag`=1 after edge SYNC_STAGES+DN_CNT-1, which is edge 5 at defaults.
- **`force_pwup` latency:** one edge from sample to `pwup_filt`=1.
- **Glitch bound:** a pulse shorter than UP_CNT synchronised samples on the rise, or DN_CNT on the fall, never changes `pwup_filt`.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **`por_pkg`:** holds the state typedef (2-bit enum LOW/QUAL_UP/HIGH/QUAL_DN) and `GLITCH_MAX`=8'hFF. Shared with the POR digital block for debug decode.
- **Sub-module `por_sync`:** parameterised N-stage synchroniser. Synchronous active-high `rst` clears every stage to 0.
- The FSM, counters and flags live in the top module.

## Test plan
- **Clean rise:** `rst` pulse, then `cmp_raw`=1 held → `pwup_filt`=1 exactly 65 edges after first capture; `glitch_cnt`=0; `filt_state` passes 00→01→10.
- **Rise glitch:** `cmp_raw` high for 30 cycles then low → `pwup_filt` stays 0, `glitch_cnt`=1, state returns to 00. 300 such pulses → `glitch_cnt`=255.
- **Brown-out:** from HIGH, `cmp_raw`=0 held → `pwup_filt`=0 after edge 5 and `bod_flag`=1. A 3-cycle low pulse instead → `pwup_filt` stays 1 and `glitch_cnt`+1.
- **Flag clear priority:** `clr_bod`=1 while `bod_flag`=1 → 0 next edge. `clr_bod` asserted on the same edge as the QUAL_DN→LOW transition → `bod_flag`=1.
- **Force:** `cmp_raw`=0, `force_pwup`=1 → `pwup_filt`=1 after 1 edge. Release it → `pwup_filt`=0 after DN_CNT further samples and `bod_flag`=1.
- **Reset mid-op:** `rst`=1 during QUAL_UP with cnt=40 → all outputs 0 next edge. Reset together with `force_pwup`=1 → `pwup_filt`=0.
